// File: rtl/obi_fixlat_pkg.sv
// Shared helpers for the fixed-latency OBI slave adapter and its response FIFO.
// Response/tag structs are declared in the users, sized by their IdWidth/BusWidth.
package obi_fixlat_pkg;

  function automatic bit fixlat_cfg_ok(input int unsigned latency, input int unsigned fifo_depth);
    return (latency >= 1) && (fifo_depth >= 1);
  endfunction

  // Pointer width that stays legal for a single-entry FIFO.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/obi_resp_fifo.sv
// Fall-through response FIFO: an arriving entry bypasses storage when the FIFO is empty.
// Storage exists only when OBI_ADAPTER_RREADY_EN is defined; otherwise this is a wire-through.
module obi_resp_fifo
  import obi_fixlat_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
`ifdef OBI_ADAPTER_RREADY_EN
  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign valid_o = !empty_o || push_i;
  assign data_o  = empty_o ? data_i : mem_q[rptr_q];

  // An entry accepted in the same cycle it arrives on an empty FIFO is never stored.
  assign do_push = push_i && !(empty_o && pop_i);
  assign do_pop  = !empty_o && pop_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  !(push_i && full_o && !pop_i))
    else $error("obi_resp_fifo: push into a full FIFO");
`else
  logic unused_fifo_in;
  assign unused_fifo_in = ^{clk_i, rst_ni, pop_i};

  assign valid_o = push_i;
  assign data_o  = data_i;
  assign full_o  = 1'b0;
  assign empty_o = 1'b1;
`endif
endmodule

// File: rtl/obi_fixlat_slave_adapter.sv
// OBI slave adapter for a fixed-latency, always-ready device with multiple outstanding requests.
// Build macro OBI_ADAPTER_RREADY_EN honours slave_rready_i and buffers responses in a FIFO.
module obi_fixlat_slave_adapter
  import obi_fixlat_pkg::*;
#(
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned BusWidth  = 32,
  parameter int unsigned Latency   = 1,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  slave_req_i,
  output logic                  slave_gnt_o,
  input  logic                  slave_we_i,
  input  logic [BusWidth-1:0]   slave_addr_i,
  input  logic [BusWidth/8-1:0] slave_be_i,
  input  logic [BusWidth-1:0]   slave_wdata_i,
  input  logic [IdWidth-1:0]    slave_aid_i,
  output logic                  slave_rvalid_o,
  input  logic                  slave_rready_i,
  output logic [BusWidth-1:0]   slave_rdata_o,
  output logic [IdWidth-1:0]    slave_rid_o,
  output logic                  dev_req_o,
  output logic                  dev_we_o,
  output logic [BusWidth-1:0]   dev_addr_o,
  output logic [BusWidth/8-1:0] dev_be_o,
  output logic [BusWidth-1:0]   dev_wdata_o,
  input  logic [BusWidth-1:0]   dev_rdata_i
);
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [IdWidth-1:0] aid;
  } obi_tag_t;

  typedef struct packed {
    logic [IdWidth-1:0]  rid;
    logic [BusWidth-1:0] rdata;
  } obi_resp_t;

  if (!fixlat_cfg_ok(Latency, FifoDepth)) begin : g_bad_cfg
    $fatal(1, "obi_fixlat_slave_adapter: Latency and FifoDepth must both be >= 1");
  end

  logic [CntW-1:0] cnt_q;
  logic            grant, retire, rready;
  obi_tag_t        tag_q [Latency];
  obi_resp_t       arr_resp, out_resp;
  logic            fifo_valid;
  logic            unused_fifo_full, unused_fifo_empty;

`ifdef OBI_ADAPTER_RREADY_EN
  assign rready = slave_rready_i;
`else
  logic unused_rready;
  assign unused_rready = slave_rready_i;
  assign rready        = 1'b1;
`endif

  // cnt covers every granted request until its response is accepted, so the FIFO cannot overflow.
  assign slave_gnt_o = !rst_ni || (cnt_q < CntW'(FifoDepth));
  assign grant       = slave_req_i && slave_gnt_o;
  assign retire      = slave_rvalid_o && rready;

  assign dev_req_o   = grant;
  assign dev_we_o    = slave_we_i;
  assign dev_addr_o  = slave_addr_i;
  assign dev_be_o    = slave_be_i;
  assign dev_wdata_o = slave_wdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_q + CntW'(grant) - CntW'(retire);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Latency); i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: grant, we: slave_we_i, aid: slave_aid_i};
      for (int i = 1; i < int'(Latency); i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    arr_resp.rid   = tag_q[Latency-1].aid;
    arr_resp.rdata = tag_q[Latency-1].we ? '0 : dev_rdata_i;
  end

  obi_resp_fifo #(
    .Width($bits(obi_resp_t)),
    .Depth(FifoDepth)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tag_q[Latency-1].valid),
    .data_i  (arr_resp),
    .pop_i   (rready),
    .valid_o (fifo_valid),
    .data_o  (out_resp),
    .full_o  (unused_fifo_full),
    .empty_o (unused_fifo_empty)
  );

  assign slave_rvalid_o = rst_ni && fifo_valid;
  assign slave_rdata_o  = slave_rvalid_o ? out_resp.rdata : '0;
  assign slave_rid_o    = slave_rvalid_o ? out_resp.rid : '0;

endmodule

// File: tb/tb_obi_fixlat_slave_adapter.sv
// Scoreboard bench for obi_fixlat_slave_adapter: instance 0 is Latency 1 / FifoDepth 2,
// instance 1 is Latency 3 / FifoDepth 3; each has a delay-line device model and its own queue.
module tb_obi_fixlat_slave_adapter;
  localparam int IW = 2;
  localparam int BW = 32;
`ifdef OBI_ADAPTER_RREADY_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  typedef struct {
    logic [IW-1:0] rid;
    logic [BW-1:0] rdata;
    int            due;
    bit            exact;
  } exp_t;
  typedef exp_t exp_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_q_t exp_q [2];

  logic          req [2], gnt [2], we [2], rvalid [2], rready [2], dev_req [2], dev_we [2];
  logic [BW-1:0] addr [2], wdata [2], rdata [2], dev_addr [2], dev_wdata [2], dev_rdata [2];
  logic [BW-1:0] dev_tag [2];
  logic [3:0]    be [2], dev_be [2];
  logic [IW-1:0] aid [2], rid [2];
  logic          held_v [2];
  logic [IW+BW-1:0] held [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int Lat = (k == 0) ? 1 : 3;
    localparam int Dep = (k == 0) ? 2 : 3;
    logic [BW-1:0] dline [Lat];

    obi_fixlat_slave_adapter #(
      .IdWidth(IW), .BusWidth(BW), .Latency(Lat), .FifoDepth(Dep)
    ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .slave_req_i(req[k]), .slave_gnt_o(gnt[k]), .slave_we_i(we[k]),
      .slave_addr_i(addr[k]), .slave_be_i(be[k]), .slave_wdata_i(wdata[k]),
      .slave_aid_i(aid[k]), .slave_rvalid_o(rvalid[k]), .slave_rready_i(rready[k]),
      .slave_rdata_o(rdata[k]), .slave_rid_o(rid[k]),
      .dev_req_o(dev_req[k]), .dev_we_o(dev_we[k]), .dev_addr_o(dev_addr[k]),
      .dev_be_o(dev_be[k]), .dev_wdata_o(dev_wdata[k]), .dev_rdata_i(dev_rdata[k])
    );

    // Device returns the tagged data Lat cycles after a read; junk otherwise.
    always @(posedge clk) begin
      dline[0] <= (dev_req[k] && !dev_we[k]) ? dev_tag[k] : 32'hBAD0_BAD0;
      for (int i = 1; i < Lat; i++) dline[i] <= dline[i-1];
    end
    assign dev_rdata[k] = dline[Lat-1];
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Starts right after a posedge; returns right after the posedge that grants.
  task automatic drive(input int k, input logic w, input logic [BW-1:0] a, input logic [IW-1:0] id,
                       input logic [BW-1:0] d, input bit exact, output int stalls);
    stalls = 0;
    req[k] = 1'b1; we[k] = w; addr[k] = a; aid[k] = id; wdata[k] = d; be[k] = 4'hF;
    dev_tag[k] = d;
    @(negedge clk);
    while (!gnt[k] && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    chk($sformatf("i%0d grant id%0d", k, id), gnt[k], 1'b1);
    if (gnt[k]) begin
      chk($sformatf("i%0d dev_req", k), dev_req[k], 1'b1);
      chk($sformatf("i%0d dev_we", k), dev_we[k], w);
      chk($sformatf("i%0d dev_addr", k), dev_addr[k], a);
      chk($sformatf("i%0d dev_wdata", k), dev_wdata[k], d);
      exp_q[k].push_back('{rid: id, rdata: w ? {BW{1'b0}} : d, due: cyc + lat_of(k), exact: exact});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    req[k] = 1'b0;
    we[k]  = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (exp_q[k].size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("i%0d drained", k), exp_q[k].size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic rr;
    for (int k = 0; k < 2; k++) begin
      rr = RrEn ? rready[k] : 1'b1;
      if (rst_n && rvalid[k] && rr) begin
        chk($sformatf("i%0d response expected", k), exp_q[k].size() != 0, 1'b1);
        if (exp_q[k].size() != 0) begin
          e = exp_q[k].pop_front();
          chk($sformatf("i%0d rid", k), rid[k], e.rid);
          chk($sformatf("i%0d rdata", k), rdata[k], e.rdata);
          if (e.exact) chk($sformatf("i%0d latency", k), cyc, e.due);
          else         chk($sformatf("i%0d not early", k), cyc >= e.due, 1'b1);
        end
      end
      if (rst_n && rvalid[k] && !rr) begin
        if (held_v[k]) chk($sformatf("i%0d stable", k), {rid[k], rdata[k]}, held[k]);
        held_v[k] = 1'b1;
        held[k]   = {rid[k], rdata[k]};
      end else begin
        held_v[k] = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; be[k] = '0; wdata[k] = '0; aid[k] = '0;
      rready[k] = 1'b1; dev_tag[k] = '0; held_v[k] = 1'b0; held[k] = '0;
    end

    // Reset values; dev_req follows the request during reset.
    req[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst gnt0", gnt[0], 1'b1);
    chk("rst gnt1", gnt[1], 1'b1);
    chk("rst rvalid0", rvalid[0], 1'b0);
    chk("rst rvalid1", rvalid[1], 1'b0);
    chk("rst rdata0", rdata[0], '0);
    chk("rst rid0", rid[0], '0);
    chk("rst dev_req follows 1", dev_req[0], 1'b1);
    req[0] = 1'b0;
    #1;
    chk("rst dev_req follows 0", dev_req[0], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle read.
    drive(0, 1'b0, 32'h10, 2'd1, 32'hDEAD_BEEF, 1'b1, st);
    idle(0);
    chk("t1 no stall", st, 0);
    @(negedge clk);
    chk("t1 gnt stays", gnt[0], 1'b1);
    @(posedge clk); #1;
    drain(0);

    // Write: device sees data, response carries zero rdata.
    drive(0, 1'b1, 32'h20, 2'd1, 32'h1234_5678, 1'b1, st);
    idle(0);
    drain(0);

    // Back-to-back on Latency 1: grant and retire coincide at cnt = FifoDepth-1.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0, 32'h100 + 32'(i * 4), IW'(i), 32'hA000_0000 + 32'(i), 1'b1, st);
      chk($sformatf("t5 stall %0d", i), st, 0);
    end
    idle(0);
    drain(0);

    // Back-to-back on Latency 3 / FifoDepth 3: cnt reaches 3 before the first retire,
    // so the fourth request waits exactly one cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b0, 32'h200 + 32'(i * 4), IW'(i), 32'hC0DE_0000 + 32'(i), 1'b1, st);
      chk($sformatf("t2 stall %0d", i), st, (i == 3) ? 1 : 0);
    end
    idle(1);
    drain(1);

    // Backpressure: with rready honoured two responses wait and the grant drops.
    rready[0] = 1'b0;
    drive(0, 1'b0, 32'h40, 2'd2, 32'h1111_0001, !RrEn, st);
    chk("t3 stall a", st, 0);
    drive(0, 1'b0, 32'h44, 2'd3, 32'h2222_0002, !RrEn, st);
    chk("t3 stall b", st, 0);
    idle(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3 gnt hold %0d", i), gnt[0], !RrEn);
      @(posedge clk); #1;
    end
    rready[0] = 1'b1;
    drive(0, 1'b0, 32'h48, 2'd0, 32'h3333_0003, 1'b1, st);
    chk("t3 stall c", st, RrEn ? 1 : 0);
    idle(0);
    drain(0);

    // Reset with two reads in flight: nothing stale may come out afterwards.
    drive(1, 1'b0, 32'h300, 2'd1, 32'h5555_0001, 1'b1, st);
    drive(1, 1'b0, 32'h304, 2'd2, 32'h5555_0002, 1'b1, st);
    idle(1);
    rst_n = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clk);
    chk("t6 rvalid in reset", rvalid[1], 1'b0);
    chk("t6 gnt in reset", gnt[1], 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6 rvalid after", rvalid[1], 1'b0);
    chk("t6 gnt after", gnt[1], 1'b1);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    drive(1, 1'b0, 32'h308, 2'd3, 32'h6666_0003, 1'b1, st);
    chk("t6 fresh stall", st, 0);
    idle(1);
    drain(1);
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
